// File: rtl/ddr_read_responder.sv
// ddr_read_responder
//   Circular read-data buffer that sits in front of a matrix unit's DDR read
//   port. The host preloads words through a ready/valid push interface. The
//   matrix unit pulls words with ddr_r_en_i and sees each word one cycle
//   later on ddr_r_data_o, qualified by ddr_r_valid_o.
//
// Parameters
//   ddr_data_t : type of one DDR read word
//   DataW      : word width, defaults to the width of ddr_data_t
//   Depth      : number of buffered words; must be a power of two, >= 2
//
// Ports
//   clk_i         : clock; all state changes on the rising edge
//   rst_ni        : synchronous active-low reset
//   clear_i       : synchronous flush of the buffer and status
//   host_valid_i  : host offers host_data_i for loading
//   host_data_i   : word offered by the host
//   host_ready_o  : buffer has room this cycle
//   ddr_r_en_i    : read request from the DDR read port
//   ddr_r_data_o  : registered read data (holds when no word is popped)
//   ddr_r_valid_o : ddr_r_data_o carries the word popped last cycle
//   underflow_o   : sticky; a request arrived while the buffer was empty
//   level_o       : number of words currently buffered (0..Depth)
module ddr_read_responder #(
    parameter type ddr_data_t = logic [31:0],
    parameter int  DataW      = $bits(ddr_data_t),
    parameter int  Depth      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       host_valid_i,
    input  logic [DataW-1:0]           host_data_i,
    output logic                       host_ready_o,
    input  logic                       ddr_r_en_i,
    output logic [DataW-1:0]           ddr_r_data_o,
    output logic                       ddr_r_valid_o,
    output logic                       underflow_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = $clog2(Depth + 1);

    logic [DataW-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [LvlW-1:0]  count;

    logic push;
    logic pop;
    logic empty;

    // Ready and pop eligibility depend on registered occupancy only, so a
    // word written this cycle cannot be read until the next one.
    assign empty        = (count == '0);
    assign host_ready_o = (count < LvlW'(Depth));
    assign push         = host_valid_i && host_ready_o;
    assign pop          = ddr_r_en_i && !empty;
    assign level_o      = count;

    // Storage carries no reset; a write is suppressed only when reset or
    // clear would discard it anyway.
    always_ff @(posedge clk_i) begin
        if (push && rst_ni && !clear_i) begin
            mem[wr_ptr] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ddr_r_valid_o <= 1'b0;
            underflow_o   <= 1'b0;
            ddr_r_data_o  <= '0;
        end else if (clear_i) begin
            // Flush overrides any same-cycle push or pop; read data holds.
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ddr_r_valid_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                ddr_r_data_o <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + PtrW'(1);
            end
            ddr_r_valid_o <= pop;
            if (ddr_r_en_i && empty) begin
                underflow_o <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + LvlW'(1);
                2'b01:   count <= count - LvlW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
